// File: rtl/typing_pkg.sv
// Shared constants for the typing round controller: state encoding and
// default widths / limits.
package typing_pkg;

  localparam int CLK_HZ_DEF        = 50_000_000;
  localparam int TIME_W_DEF        = 4;
  localparam int SCORE_W_DEF       = 8;
  localparam int DEFAULT_LIMIT_DEF = 10;

  // Round phase encoding, also presented on state_o.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/typing_round_ctrl_tick_gen.sv
// One-second prescaler: emits a single-cycle tick every CLK_HZ cycles.
// While clear is high the count is held at zero, so the first tick after
// clear drops arrives exactly CLK_HZ cycles later.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  // Free-running count that wraps on the last cycle of each period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/typing_round_ctrl.sv
// Typing round controller: drives the countdown timer, runs the 3-2-1
// pre-round countdown, tallies keystrokes while the round runs and flags
// whether the round ended by time expiry or by abort.
module typing_round_ctrl
  import typing_pkg::*;
#(
  parameter int CLK_HZ        = CLK_HZ_DEF,
  parameter int TIME_W        = TIME_W_DEF,
  parameter int DEFAULT_LIMIT = DEFAULT_LIMIT_DEF,
  parameter int SCORE_W       = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [TIME_W-1:0]  limit_sel,
  input  logic               key_valid,
  input  logic               key_correct,
  input  logic [TIME_W-1:0]  time_left,
  output logic               timer_reset,
  output logic               timer_enable,
  output logic [TIME_W-1:0]  time_limit,
  output logic [1:0]         state_o,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] errors,
  output logic               round_done,
  output logic               timeout
);

  localparam logic [TIME_W-1:0] DEF_LIM = TIME_W'(DEFAULT_LIMIT);

  logic              tick;
  logic              tick_clear;
  logic [1:0]        state_nx;
  logic              expired;
  logic              enter_ready;
  logic [TIME_W-1:0] prev_time_left;

  // Prescaler only runs during the pre-round countdown.
  assign tick_clear = (state_o != ST_READY);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Round expiry: timer reached zero, or it wrapped upward past its last value.
  always_comb begin
    expired = (time_left == '0) || (time_left > prev_time_left);
  end

  // Next-phase decision; expiry beats abort in RUN, abort beats start in DONE.
  always_comb begin
    state_nx = state_o;
    case (state_o)
      ST_IDLE: begin
        if (start) state_nx = ST_READY;
        else       state_nx = ST_IDLE;
      end
      ST_READY: begin
        if (abort)                           state_nx = ST_IDLE;
        else if (tick && countdown == 2'd1)  state_nx = ST_RUN;
        else                                 state_nx = ST_READY;
      end
      ST_RUN: begin
        if (expired || abort) state_nx = ST_DONE;
        else                  state_nx = ST_RUN;
      end
      ST_DONE: begin
        if (abort)      state_nx = ST_IDLE;
        else if (start) state_nx = ST_READY;
        else            state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign enter_ready = (state_o != ST_READY) && (state_nx == ST_READY);

  // Registered phase, timer controls, countdown, tallies and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_o        <= ST_IDLE;
      timer_reset    <= 1'b1;
      timer_enable   <= 1'b0;
      time_limit     <= DEF_LIM;
      countdown      <= 2'd0;
      score          <= '0;
      errors         <= '0;
      round_done     <= 1'b0;
      timeout        <= 1'b0;
      prev_time_left <= DEF_LIM;
    end else begin
      state_o      <= state_nx;
      timer_reset  <= (state_nx == ST_IDLE) || (state_nx == ST_READY);
      timer_enable <= (state_nx == ST_RUN);
      round_done   <= (state_o == ST_RUN) && (state_nx == ST_DONE);

      // Outside RUN, track the limit so RUN entry starts from time_limit.
      if (state_o == ST_RUN) prev_time_left <= time_left;
      else                   prev_time_left <= time_limit;

      if (enter_ready) begin
        time_limit <= (limit_sel == '0) ? DEF_LIM : limit_sel;
        countdown  <= 2'd3;
        score      <= '0;
        errors     <= '0;
        timeout    <= 1'b0;
      end else begin
        if (state_nx != ST_READY) countdown <= 2'd0;
        else if (tick)            countdown <= countdown - 2'd1;
        else                      countdown <= countdown;

        if (state_o == ST_RUN) begin
          if (key_valid && key_correct && (score != '1))   score  <= score + SCORE_W'(1);
          if (key_valid && !key_correct && (errors != '1)) errors <= errors + SCORE_W'(1);
          if (state_nx == ST_DONE) timeout <= expired;
        end
      end
    end
  end

endmodule

// File: tb/tb_typing_round_ctrl.sv
// Self-checking bench for typing_round_ctrl with CLK_HZ=4. A behavioural
// round model tracks elapsed countdown cycles and unbounded tallies; two DUTs
// (SCORE_W=8 and SCORE_W=2) share all inputs to exercise saturation.
module tb_typing_round_ctrl;

  localparam int CLK_HZ = 4;
  localparam int TW     = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [TW-1:0] limit_sel = '0;
  logic          key_valid = 1'b0;
  logic          key_correct = 1'b0;
  logic [TW-1:0] time_left = '0;

  logic          timer_reset, timer_enable, round_done, timeout;
  logic [TW-1:0] time_limit;
  logic [1:0]    state_o, countdown;
  logic [7:0]    score, errors;

  logic          timer_reset2, timer_enable2, round_done2, timeout2;
  logic [TW-1:0] time_limit2;
  logic [1:0]    state2, countdown2;
  logic [1:0]    score2, errors2;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model state
  int m_st, m_rc, m_limit, m_prev, m_score, m_err;
  bit m_done, m_timeout;

  typing_round_ctrl #(.CLK_HZ(CLK_HZ), .TIME_W(TW), .DEFAULT_LIMIT(10), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .limit_sel(limit_sel),
    .key_valid(key_valid), .key_correct(key_correct), .time_left(time_left),
    .timer_reset(timer_reset), .timer_enable(timer_enable), .time_limit(time_limit),
    .state_o(state_o), .countdown(countdown), .score(score), .errors(errors),
    .round_done(round_done), .timeout(timeout));

  typing_round_ctrl #(.CLK_HZ(CLK_HZ), .TIME_W(TW), .DEFAULT_LIMIT(10), .SCORE_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .limit_sel(limit_sel),
    .key_valid(key_valid), .key_correct(key_correct), .time_left(time_left),
    .timer_reset(timer_reset2), .timer_enable(timer_enable2), .time_limit(time_limit2),
    .state_o(state2), .countdown(countdown2), .score(score2), .errors(errors2),
    .round_done(round_done2), .timeout(timeout2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_rc = 0; m_limit = 10; m_prev = 10;
    m_score = 0; m_err = 0; m_done = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic model_enter_ready();
    m_st = 1; m_rc = 0;
    m_limit = (limit_sel == 0) ? 10 : int'(limit_sel);
    m_score = 0; m_err = 0; m_timeout = 1'b0;
  endtask

  // One clock edge of the round rules, applied to the inputs present at the edge.
  task automatic model_step();
    bit exp_now;
    m_done = 1'b0;
    case (m_st)
      0: if (start) model_enter_ready();
      1: begin
        if (abort) m_st = 0;
        else begin
          m_rc++;
          if (m_rc == 3 * CLK_HZ) begin m_st = 2; m_prev = m_limit; end
        end
      end
      2: begin
        if (key_valid && key_correct)  m_score++;
        if (key_valid && !key_correct) m_err++;
        exp_now = (time_left == 0) || (int'(time_left) > m_prev);
        m_prev = int'(time_left);
        if (exp_now)    begin m_st = 3; m_timeout = 1'b1; m_done = 1'b1; end
        else if (abort) begin m_st = 3; m_timeout = 1'b0; m_done = 1'b1; end
      end
      default: begin
        if (abort)      m_st = 0;
        else if (start) model_enter_ready();
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic start_round(input int lim);
    limit_sel = TW'(lim);
    time_left = (lim == 0) ? TW'(10) : TW'(lim);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3 * CLK_HZ) step();
  endtask

  // Compare every output of both DUTs against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state_o), m_st);
      chk("countdown", int'(countdown), (m_st == 1) ? 3 - m_rc / CLK_HZ : 0);
      chk("timer_reset", int'(timer_reset), (m_st <= 1) ? 1 : 0);
      chk("timer_enable", int'(timer_enable), (m_st == 2) ? 1 : 0);
      chk("time_limit", int'(time_limit), m_limit);
      chk("score", int'(score), sat(m_score, 255));
      chk("errors", int'(errors), sat(m_err, 255));
      chk("round_done", int'(round_done), int'(m_done));
      chk("timeout", int'(timeout), int'(m_timeout));
      chk("state2", int'(state2), m_st);
      chk("countdown2", int'(countdown2), (m_st == 1) ? 3 - m_rc / CLK_HZ : 0);
      chk("timer_reset2", int'(timer_reset2), (m_st <= 1) ? 1 : 0);
      chk("timer_enable2", int'(timer_enable2), (m_st == 2) ? 1 : 0);
      chk("time_limit2", int'(time_limit2), m_limit);
      chk("score2", int'(score2), sat(m_score, 3));
      chk("errors2", int'(errors2), sat(m_err, 3));
      chk("round_done2", int'(round_done2), int'(m_done));
      chk("timeout2", int'(timeout2), int'(m_timeout));
    end
  end

  initial begin
    int tl;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_timer_reset", int'(timer_reset), 1);
    chk("rst_time_limit", int'(time_limit), 10);
    chk("rst_round_done", int'(round_done), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    step();

    // 1: limit 3, countdown 3,2,1 at 4-cycle spacing, then expire 3,2,1,0.
    limit_sel = 4'd3; time_left = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_cd3", int'(countdown), 3);
    chk("t1_limit", int'(time_limit), 3);
    repeat (4) step();
    chk("t1_cd2", int'(countdown), 2);
    repeat (4) step();
    chk("t1_cd1", int'(countdown), 1);
    repeat (4) step();
    chk("t1_run", int'(state_o), 2);
    chk("t1_treset", int'(timer_reset), 0);
    chk("t1_tenable", int'(timer_enable), 1);
    step();
    time_left = 4'd2; step();
    time_left = 4'd1; step();
    chk("t1_still_run", int'(state_o), 2);
    time_left = 4'd0; step();
    chk("t1_done", int'(state_o), 3);
    chk("t1_pulse", int'(round_done), 1);
    chk("t1_timeout", int'(timeout), 1);
    step();
    chk("t1_pulse_end", int'(round_done), 0);

    // 2: 5 correct + 2 wrong keys; narrow instance saturates at 3.
    start_round(9);
    key_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      key_correct = (i < 5);
      step();
    end
    key_valid = 1'b0;
    step();
    chk("t2_score", int'(score), 5);
    chk("t2_errors", int'(errors), 2);
    chk("t2_score_sat", int'(score2), 3);
    chk("t2_errors_w2", int'(errors2), 2);

    // 3: wrap 1 -> 15 ends the round; limit_sel 0 selects the default.
    time_left = 4'd1; step();
    time_left = 4'd15; step();
    chk("t3_wrap_done", int'(state_o), 3);
    chk("t3_wrap_timeout", int'(timeout), 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t3_idle", int'(state_o), 0);
    limit_sel = 4'd0; start = 1'b1; step(); start = 1'b0;
    chk("t3_default", int'(time_limit), 10);

    // 4: abort in READY, abort in RUN, abort+expiry, restart from DONE.
    abort = 1'b1; step(); abort = 1'b0;
    chk("t4_ready_abort", int'(state_o), 0);
    start_round(6);
    key_valid = 1'b1; key_correct = 1'b0; abort = 1'b1; step();
    key_valid = 1'b0; abort = 1'b0;
    chk("t4_run_abort", int'(state_o), 3);
    chk("t4_abort_to", int'(timeout), 0);
    limit_sel = 4'd5; start = 1'b1; step(); start = 1'b0;
    chk("t4_restart", int'(state_o), 1);
    chk("t4_restart_err", int'(errors), 0);
    repeat (3 * CLK_HZ) step();
    time_left = 4'd0; abort = 1'b1; step(); abort = 1'b0;
    chk("t4_both_to", int'(timeout), 1);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("t4_abort_wins", int'(state_o), 0);

    // 5: asynchronous reset between edges mid-RUN.
    start_round(8);
    key_valid = 1'b1; key_correct = 1'b1; step(); key_valid = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t5_state", int'(state_o), 0);
    chk("t5_treset", int'(timer_reset), 1);
    chk("t5_tenable", int'(timer_enable), 0);
    chk("t5_score", int'(score), 0);
    chk("t5_limit", int'(time_limit), 10);
    step();
    reset = 1'b0;
    step();

    // Random traffic against the model.
    tl = 10;
    for (int c = 0; c < 4000; c++) begin
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 29) == 0);
      limit_sel   = TW'($urandom_range(0, 15));
      key_valid   = ($urandom_range(0, 2) == 0);
      key_correct = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0)     tl = $urandom_range(0, 15);
      else if (m_st != 2)                 tl = m_limit;
      else if ($urandom_range(0, 4) == 0) tl = (tl > 0) ? tl - 1 : 0;
      time_left = TW'(tl);
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
